// File: rtl/kp_sched_pkg.sv
// -----------------------------------------------------------------------------
// kp_sched_pkg
//   Shared types and helpers for the kernel frame scheduler (kp_kernel_sched)
//   and its source FIFO (kp_sync_fifo).
//
//   sched_state_t  : scheduler FSM states
//   pixel_t        : default-width pixel word
//   frame_pixels() : number of pixels in one frame
// -----------------------------------------------------------------------------
package kp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

    localparam int PIXEL_WIDTH = 16;
    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    function automatic int frame_pixels(input int line_length, input int line_count);
        return line_length * line_count;
    endfunction

endpackage

// File: rtl/kp_sync_fifo.sv
// -----------------------------------------------------------------------------
// kp_sync_fifo
//   Single-clock FIFO for the scheduler's source skid buffer. The head entry is
//   presented on o_data whenever o_empty is low; a push into an empty FIFO only
//   becomes visible the following cycle (no fall-through).
//
//   Ports:
//     i_clk, i_rstn : clock, asynchronous active-low reset
//     i_clr         : synchronous clear (drops all entries)
//     i_push/i_data : write one entry (ignored when full)
//     i_pop         : retire the head entry (ignored when empty)
//     o_data        : head entry
//     o_full/o_empty: occupancy flags
// -----------------------------------------------------------------------------
module kp_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_data  = mem[rd_ptr[AW-1:0]];

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/kp_kernel_sched.sv
// -----------------------------------------------------------------------------
// kp_kernel_sched
//   Frame-level scheduler for the 3x3 kernel line-buffer controller. Buffers
//   source pixels, answers kernel-controller pixel requests one cycle after
//   they can be served, repeats the last pixel for one extra line so the final
//   window row drains, and tags window outputs with frame coordinates.
//
//   Ports:
//     i_clk, i_rstn          : clock, asynchronous active-low reset
//     i_start                : one-cycle frame start (only honoured in IDLE)
//     i_src_data/valid,
//     o_src_ready            : upstream pixel ready/valid
//     i_kc_req               : kernel controller pixel request
//     o_kc_data/o_kc_valid   : registered pixel response
//     i_kc_win_valid         : kernel controller window valid
//     o_col/o_row            : coordinates of the current window
//     o_sof/o_eol/o_eof      : window markers, combinational with i_kc_win_valid
//     o_busy                 : scheduler not IDLE
//     o_frame_done           : one-cycle pulse after the last window
//     o_stall_cnt            : cycles in STREAM with requests waiting on an
//                              empty FIFO; only counted when KP_SCHED_STATS_EN
//                              is defined, otherwise tied to zero
// -----------------------------------------------------------------------------
module kp_kernel_sched
    import kp_sched_pkg::*;
#(
    parameter int LINE_LENGTH = 480,
    parameter int LINE_COUNT  = 480,
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rstn,
    input  logic                           i_start,
    input  logic [DATA_WIDTH-1:0]          i_src_data,
    input  logic                           i_src_valid,
    output logic                           o_src_ready,
    input  logic                           i_kc_req,
    output logic [DATA_WIDTH-1:0]          o_kc_data,
    output logic                           o_kc_valid,
    input  logic                           i_kc_win_valid,
    output logic [$clog2(LINE_LENGTH)-1:0] o_col,
    output logic [$clog2(LINE_COUNT)-1:0]  o_row,
    output logic                           o_sof,
    output logic                           o_eol,
    output logic                           o_eof,
    output logic                           o_busy,
    output logic                           o_frame_done,
    output logic [31:0]                    o_stall_cnt
);

    localparam int FRAME   = frame_pixels(LINE_LENGTH, LINE_COUNT);
    localparam int IN_W    = $clog2(FRAME + 1);
    localparam int PEND_W  = $clog2(FIFO_DEPTH + 1);
    localparam int FLUSH_W = $clog2(LINE_LENGTH + 1);
    localparam int COL_W   = $clog2(LINE_LENGTH);
    localparam int ROW_W   = $clog2(LINE_COUNT);

    localparam logic [IN_W-1:0]    FRAME_CNT = IN_W'(FRAME);
    localparam logic [PEND_W-1:0]  PEND_MAX  = PEND_W'(FIFO_DEPTH);
    localparam logic [FLUSH_W-1:0] FLUSH_MAX = FLUSH_W'(LINE_LENGTH);
    localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(LINE_LENGTH - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(LINE_COUNT - 1);

    sched_state_t          state, state_nxt;
    logic [IN_W-1:0]       in_cnt;
    logic [PEND_W-1:0]     pending;
    logic [FLUSH_W-1:0]    flush_cnt;
    logic [COL_W-1:0]      out_col;
    logic [ROW_W-1:0]      out_row;
    logic [DATA_WIDTH-1:0] last_pix;
    logic [DATA_WIDTH-1:0] kc_data;
    logic                  kc_valid;

    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    logic frame_start, src_ready, push, req_live, want;
    logic serve_stream, serve_flush, serve, win_live, sof, eol, eof;

    kp_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_clr   (frame_start),
        .i_push  (push),
        .i_data  (i_src_data),
        .i_pop   (serve_stream),
        .o_data  (fifo_rd_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        frame_start  = (state == IDLE) && i_start;
        src_ready    = (state == STREAM) && !fifo_full && (in_cnt < FRAME_CNT);
        push         = i_src_valid && src_ready;
        // Once a full flush line has been served, further requests are dropped.
        req_live     = i_kc_req && ((state == STREAM) ||
                                    ((state == FLUSH) && (flush_cnt < FLUSH_MAX)));
        // A request arriving this cycle is served immediately if data is there.
        want         = (pending != '0) || req_live;
        serve_stream = (state == STREAM) && want && !fifo_empty;
        serve_flush  = (state == FLUSH) && want && (flush_cnt < FLUSH_MAX);
        serve        = serve_stream || serve_flush;
        win_live     = i_kc_win_valid && ((state == STREAM) || (state == FLUSH));
        sof          = win_live && (out_col == '0) && (out_row == '0);
        eol          = win_live && (out_col == COL_LAST);
        eof          = eol && (out_row == ROW_LAST);

        state_nxt = state;
        unique case (state)
            IDLE:    if (i_start) state_nxt = STREAM;
            STREAM:  if (eof) state_nxt = DONE;
                     else if ((in_cnt == FRAME_CNT) && fifo_empty) state_nxt = FLUSH;
            FLUSH:   if (eof) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            in_cnt    <= '0;
            pending   <= '0;
            flush_cnt <= '0;
            out_col   <= '0;
            out_row   <= '0;
            last_pix  <= '0;
            kc_data   <= '0;
            kc_valid  <= 1'b0;
        end else begin
            kc_valid <= serve;
            if (serve) kc_data <= serve_flush ? last_pix : fifo_rd_data;

            if (frame_start) begin
                in_cnt    <= '0;
                pending   <= '0;
                flush_cnt <= '0;
                out_col   <= '0;
                out_row   <= '0;
            end else begin
                if (push) begin
                    in_cnt   <= in_cnt + IN_W'(1);
                    last_pix <= i_src_data;
                end
                if (serve_flush) flush_cnt <= flush_cnt + FLUSH_W'(1);

                if ((state == FLUSH) && (flush_cnt == FLUSH_MAX)) begin
                    pending <= '0;
                end else if (req_live && !serve) begin
                    if (pending != PEND_MAX) pending <= pending + PEND_W'(1);
                end else if (!req_live && serve) begin
                    pending <= pending - PEND_W'(1);
                end

                if (win_live) begin
                    if (out_col == COL_LAST) begin
                        out_col <= '0;
                        out_row <= (out_row == ROW_LAST) ? '0 : out_row + ROW_W'(1);
                    end else begin
                        out_col <= out_col + COL_W'(1);
                    end
                end
            end
        end
    end

`ifdef KP_SCHED_STATS_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_cnt <= '0;
        end else if (frame_start) begin
            stall_cnt <= '0;
        end else if ((state == STREAM) && (pending != '0) && fifo_empty &&
                     (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

    assign o_src_ready  = src_ready;
    assign o_kc_data    = kc_data;
    assign o_kc_valid   = kc_valid;
    assign o_col        = out_col;
    assign o_row        = out_row;
    assign o_sof        = sof;
    assign o_eol        = eol;
    assign o_eof        = eof;
    assign o_busy       = (state != IDLE);
    assign o_frame_done = (state == DONE);

endmodule

// File: tb/tb_kp_kernel_sched.sv
// -----------------------------------------------------------------------------
// tb_kp_kernel_sched
//   Directed bench for kp_kernel_sched with an 8x4 frame and a 4-entry FIFO.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_kp_kernel_sched;

    localparam int LL = 8;
    localparam int LC = 4;
    localparam int DW = 16;
    localparam int FD = 4;

`ifdef KP_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic          kc_req;
    logic [DW-1:0] kc_data;
    logic          kc_valid;
    logic          win_valid;
    logic [2:0]    col;
    logic [1:0]    row;
    logic          sof, eol, eof, busy, frame_done;
    logic [31:0]   stall_cnt;

    always #5 clk = ~clk;

    kp_kernel_sched #(
        .LINE_LENGTH (LL),
        .LINE_COUNT  (LC),
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_start        (start),
        .i_src_data     (src_data),
        .i_src_valid    (src_valid),
        .o_src_ready    (src_ready),
        .i_kc_req       (kc_req),
        .o_kc_data      (kc_data),
        .o_kc_valid     (kc_valid),
        .i_kc_win_valid (win_valid),
        .o_col          (col),
        .o_row          (row),
        .o_sof          (sof),
        .o_eol          (eol),
        .o_eof          (eof),
        .o_busy         (busy),
        .o_frame_done   (frame_done),
        .o_stall_cnt    (stall_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Window tagging vectors: one entry per cycle, some cycles without a pulse.
    typedef struct {
        logic       win;
        logic [2:0] col;
        logic [1:0] row;
        logic       sof;
        logic       eol;
        logic       eof;
    } win_vec_t;

    // Stall / FIFO-full sequence: per-cycle inputs and expected outputs.
    typedef struct {
        logic          sv;
        logic [DW-1:0] data;
        logic          req;
        logic          rdy;
        logic          kcv;
        logic [DW-1:0] kcd;
        int            stall;
    } f2_vec_t;

    function automatic f2_vec_t mk2(input logic sv, input logic [DW-1:0] data, input logic req,
                                    input logic rdy, input logic kcv, input logic [DW-1:0] kcd,
                                    input int stall);
        f2_vec_t v;
        v.sv = sv; v.data = data; v.req = req;
        v.rdy = rdy; v.kcv = kcv; v.kcd = kcd; v.stall = stall;
        return v;
    endfunction

    win_vec_t    win_tbl [34];
    f2_vec_t     f2_tbl  [21];
    int          pushed;
    int          served;
    int          kc_seen;
    int          p;
    logic        exp_ready;
    logic        exp_kcv;
    logic        prev_serve;
    logic [11:0] req_pat;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- stimulus tables ----------------
        p = 0;
        for (int k = 0; k < 34; k++) begin
            if (k == 5 || k == 20) begin
                win_tbl[k].win = 1'b0;
                win_tbl[k].col = 3'(p % 8);
                win_tbl[k].row = 2'(p / 8);
                win_tbl[k].sof = 1'b0;
                win_tbl[k].eol = 1'b0;
                win_tbl[k].eof = 1'b0;
            end else begin
                win_tbl[k].win = 1'b1;
                win_tbl[k].col = 3'(p % 8);
                win_tbl[k].row = 2'(p / 8);
                win_tbl[k].sof = (p == 0);
                win_tbl[k].eol = ((p % 8) == 7);
                win_tbl[k].eof = (p == 31);
                p++;
            end
        end

        //                  sv  data      req rdy kcv kcd       stall
        f2_tbl[0]  = mk2(0, 16'h0000, 1, 1, 0, 16'h0000, 0);
        f2_tbl[1]  = mk2(0, 16'h0000, 1, 1, 0, 16'h0000, 0);
        f2_tbl[2]  = mk2(0, 16'h0000, 1, 1, 0, 16'h0000, 1);
        f2_tbl[3]  = mk2(0, 16'h0000, 0, 1, 0, 16'h0000, 2);
        f2_tbl[4]  = mk2(0, 16'h0000, 0, 1, 0, 16'h0000, 3);
        f2_tbl[5]  = mk2(1, 16'h0A01, 0, 1, 0, 16'h0000, 4);
        f2_tbl[6]  = mk2(1, 16'h0A02, 0, 1, 0, 16'h0000, 5);
        f2_tbl[7]  = mk2(1, 16'h0A03, 0, 1, 1, 16'h0A01, 5);
        f2_tbl[8]  = mk2(1, 16'h0A04, 0, 1, 1, 16'h0A02, 5);
        f2_tbl[9]  = mk2(0, 16'h0000, 0, 1, 1, 16'h0A03, 5);
        f2_tbl[10] = mk2(0, 16'h0000, 0, 1, 0, 16'h0000, 5);
        f2_tbl[11] = mk2(0, 16'h0000, 1, 1, 0, 16'h0000, 5);
        f2_tbl[12] = mk2(0, 16'h0000, 0, 1, 1, 16'h0A04, 5);
        f2_tbl[13] = mk2(1, 16'h0B01, 0, 1, 0, 16'h0000, 5);
        f2_tbl[14] = mk2(1, 16'h0B02, 0, 1, 0, 16'h0000, 5);
        f2_tbl[15] = mk2(1, 16'h0B03, 0, 1, 0, 16'h0000, 5);
        f2_tbl[16] = mk2(1, 16'h0B04, 0, 1, 0, 16'h0000, 5);
        f2_tbl[17] = mk2(1, 16'h0B05, 0, 0, 0, 16'h0000, 5);
        f2_tbl[18] = mk2(1, 16'h0B05, 1, 0, 0, 16'h0000, 5);
        f2_tbl[19] = mk2(1, 16'h0B05, 1, 1, 1, 16'h0B01, 5);
        f2_tbl[20] = mk2(0, 16'h0000, 0, 1, 1, 16'h0B02, 5);

        // ---------------- reset held with live inputs ----------------
        rstn = 1'b0; start = 1'b0; src_valid = 1'b1; src_data = 16'h1234;
        kc_req = 1'b1; win_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_src_ready",  32'(src_ready),  0);
        check("rst_kc_valid",   32'(kc_valid),   0);
        check("rst_kc_data",    32'(kc_data),    0);
        check("rst_busy",       32'(busy),       0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_stall_cnt",  stall_cnt,       0);

        @(negedge clk);
        rstn = 1'b1; src_valid = 1'b0; kc_req = 1'b0;

        // ---------------- frame 1: full stream, req each cycle ----------------
        @(negedge clk);
        start = 1'b1;
        pushed = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            start     = (i == 10);           // must be ignored while busy
            src_valid = 1'b1;
            src_data  = 16'(pushed + 1);
            kc_req    = (i < 32);
            #1;
            exp_ready = (pushed < 32);
            check("f1_src_ready", 32'(src_ready), 32'(exp_ready));
            exp_kcv = (i >= 2) && (i <= 33);
            check("f1_kc_valid", 32'(kc_valid), 32'(exp_kcv));
            if (exp_kcv) check("f1_kc_data", 32'(kc_data), i - 1);
            if (exp_ready) pushed++;
        end
        src_valid = 1'b0;
        kc_req    = 1'b0;
        check("f1_busy",  32'(busy), 1);
        check("f1_stall", stall_cnt, 0);

        // ---------------- flush: 9 requests, last one dropped ----------------
        req_pat    = 12'b0110_1111_0111;
        served     = 0;
        kc_seen    = 0;
        prev_serve = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            kc_req = req_pat[j];
            #1;
            check("flush_kc_valid", 32'(kc_valid), 32'(prev_serve));
            if (prev_serve) check("flush_kc_data", 32'(kc_data), 32'h20);
            if (kc_valid === 1'b1) kc_seen++;
            prev_serve = req_pat[j] && (served < 8);
            if (prev_serve) served++;
        end
        kc_req = 1'b0;
        check("flush_total_served", kc_seen, 8);

        // ---------------- window tagging ----------------
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            win_valid = win_tbl[k].win;
            #1;
            check("win_sof", 32'(sof), 32'(win_tbl[k].sof));
            check("win_eol", 32'(eol), 32'(win_tbl[k].eol));
            check("win_eof", 32'(eof), 32'(win_tbl[k].eof));
            check("win_col", 32'(col), 32'(win_tbl[k].col));
            check("win_row", 32'(row), 32'(win_tbl[k].row));
            check("win_no_done", 32'(frame_done), 0);
        end
        @(negedge clk);
        win_valid = 1'b0;
        #1;
        check("done_pulse", 32'(frame_done), 1);
        check("done_busy",  32'(busy), 1);
        @(negedge clk);
        #1;
        check("done_pulse_end", 32'(frame_done), 0);
        check("idle_busy",      32'(busy), 0);

        // Activity in IDLE must not move anything.
        @(negedge clk);
        win_valid = 1'b1; kc_req = 1'b1; src_valid = 1'b1;
        #1;
        check("idle_sof",       32'(sof), 0);
        check("idle_eol",       32'(eol), 0);
        check("idle_src_ready", 32'(src_ready), 0);
        @(negedge clk);
        win_valid = 1'b0; kc_req = 1'b0; src_valid = 1'b0;
        #1;
        check("idle_col",      32'(col), 0);
        check("idle_row",      32'(row), 0);
        check("idle_kc_valid", 32'(kc_valid), 0);

        // ---------------- frame 2: stall, FIFO full, push+pop ----------------
        @(negedge clk);
        start = 1'b1;
        for (int t = 0; t < 21; t++) begin
            @(negedge clk);
            start     = 1'b0;
            src_valid = f2_tbl[t].sv;
            src_data  = f2_tbl[t].data;
            kc_req    = f2_tbl[t].req;
            #1;
            check("f2_src_ready", 32'(src_ready), 32'(f2_tbl[t].rdy));
            check("f2_kc_valid",  32'(kc_valid),  32'(f2_tbl[t].kcv));
            if (f2_tbl[t].kcv) check("f2_kc_data", 32'(kc_data), 32'(f2_tbl[t].kcd));
            check("f2_stall_cnt", stall_cnt, STATS ? f2_tbl[t].stall : 0);
        end

        // Asynchronous reset mid-stream.
        rstn = 1'b0;
        #1;
        check("arst_src_ready", 32'(src_ready), 0);
        check("arst_kc_valid",  32'(kc_valid),  0);
        check("arst_kc_data",   32'(kc_data),   0);
        check("arst_busy",      32'(busy),      0);
        check("arst_stall",     stall_cnt,      0);
        src_valid = 1'b0;
        kc_req    = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            #1;
            check("arst_no_done", 32'(frame_done), 0);
        end
        @(negedge clk);
        rstn = 1'b1;

        // ---------------- frame 3: restart after abort ----------------
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        kc_req = 1'b1;
        #1;
        check("f3_busy", 32'(busy), 1);
        check("f3_col",  32'(col), 0);
        check("f3_row",  32'(row), 0);
        @(negedge clk);
        kc_req    = 1'b0;
        win_valid = 1'b1;
        #1;
        check("f3_fifo_empty", 32'(kc_valid), 0);
        check("f3_sof",        32'(sof), 1);
        check("f3_eol",        32'(eol), 0);
        @(negedge clk);
        win_valid = 1'b0;
        #1;
        check("f3_col_step", 32'(col), 1);
        check("f3_no_done",  32'(frame_done), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
